// File: rtl/twiddle_fetch_ctrl_if.sv
// Job, ROM and twiddle-stream signals of twiddle_fetch_ctrl in one bundle.
// The slave view belongs to the controller; master is the environment side.
interface twiddle_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_re_data;
  logic [DATA_W-1:0] rom_im_data;
  logic              tw_valid;
  logic              tw_ready;
  logic [DATA_W-1:0] tw_re;
  logic [DATA_W-1:0] tw_im;
  logic              tw_last;

  modport slave (
    input  start, base_addr, stride, count, rom_re_data, rom_im_data, tw_ready,
    output busy, done, err, rom_addr, tw_valid, tw_re, tw_im, tw_last
  );

  modport master (
    output start, base_addr, stride, count, rom_re_data, rom_im_data, tw_ready,
    input  busy, done, err, rom_addr, tw_valid, tw_re, tw_im, tw_last
  );
endinterface

// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle-factor fetch sequencer: walks the ROM pair with a modular stride
// and streams {re, im, last} through a skid buffer sized to hide ROM latency.
module twiddle_fetch_ctrl #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 28,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  twiddle_fetch_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(DEPTH);
  localparam logic [OCC_W:0]   FULL_V  = (OCC_W + 1)'(BUF_DEPTH);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_issued;
  logic [1:0]        r_fly_v;
  logic [1:0]        r_fly_last;
  logic [DATA_W-1:0] r_buf_re [BUF_DEPTH];
  logic [DATA_W-1:0] r_buf_im [BUF_DEPTH];
  logic              r_buf_last [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [OCC_W-1:0]  r_occ;

  logic              w_load, w_issue, w_issue_last;
  logic              w_push, w_pop, w_can_issue, w_bad_job;
  logic [OCC_W:0]    w_pending;
  logic [CNT_W-1:0]  w_addr_sum;
  logic [ADDR_W-1:0] w_addr_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue gating counts reads still in flight so a push can never hit a full buffer.
  always_comb begin
    w_pop       = (r_occ != '0) && bus.tw_ready;
    w_push      = r_fly_v[1];
    w_pending   = (OCC_W + 1)'(r_occ) + (OCC_W + 1)'(r_fly_v[0]) + (OCC_W + 1)'(r_fly_v[1]);
    w_can_issue = (w_pending < FULL_V) && (r_issued < r_count);
    w_bad_job   = (CNT_W'(bus.base_addr) >= DEPTH_V) || (CNT_W'(bus.stride) >= DEPTH_V);
    w_addr_sum  = CNT_W'(r_rom_addr) + CNT_W'(r_stride);
    w_addr_nxt  = (w_addr_sum >= DEPTH_V) ? ADDR_W'(w_addr_sum - DEPTH_V) : ADDR_W'(w_addr_sum);
  end

  // FSM state and status register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic; a start coinciding with the done pulse is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_load       = 1'b0;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !r_done) begin
          if (w_bad_job) begin
            w_err_nxt = 1'b1;
          end else if (bus.count == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_issue      = 1'b1;
            w_issue_last = (bus.count == CNT_W'(1));
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (r_issued == r_count) begin
          w_state_nxt = S_DRAIN;
        end else if (w_can_issue) begin
          w_issue      = 1'b1;
          w_issue_last = (CNT_W'(r_issued + CNT_W'(1)) == r_count);
          if (w_issue_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && r_buf_last[r_rptr]) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address walk, job latches and in-flight read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_stride   <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_fly_v    <= '0;
      r_fly_last <= '0;
    end else begin
      if (w_load) begin
        r_rom_addr <= bus.base_addr;
        r_stride   <= bus.stride;
        r_count    <= bus.count;
        r_issued   <= CNT_W'(1);
      end else if (w_issue) begin
        r_rom_addr <= w_addr_nxt;
        r_issued   <= r_issued + CNT_W'(1);
      end
      r_fly_v    <= {r_fly_v[0], w_issue};
      r_fly_last <= {r_fly_last[0], w_issue_last};
    end
  end

  // Skid buffer: captures ROM data as reads land, pops on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        r_buf_re[i]   <= '0;
        r_buf_im[i]   <= '0;
        r_buf_last[i] <= 1'b0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_buf_re[r_wptr]   <= bus.rom_re_data;
        r_buf_im[r_wptr]   <= bus.rom_im_data;
        r_buf_last[r_wptr] <= r_fly_last[1];
        r_wptr             <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
      else if (!w_push && w_pop) r_occ <= r_occ - OCC_W'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_occ == OCC_MAX)));

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.rom_addr = r_rom_addr;
  assign bus.tw_valid = (r_occ != '0);
  assign bus.tw_re    = r_buf_re[r_rptr];
  assign bus.tw_im    = r_buf_im[r_rptr];
  assign bus.tw_last  = r_buf_last[r_rptr];

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Directed bench for twiddle_fetch_ctrl with a synchronous ROM model.
module tb_twiddle_fetch_ctrl;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  twiddle_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  twiddle_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(28), .BUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // ROM pair: re = {00, addr}, im = {FF, addr}, one-cycle registered read.
  always @(posedge clk) begin
    bus.rom_re_data <= {8'h00, 3'b000, bus.rom_addr};
    bus.rom_im_data <= {8'hFF, 3'b000, bus.rom_addr};
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int done_cyc = -1;
  int err_cyc  = -1;
  int rdy_mode = 0;
  logic [DATA_W-1:0] hs_re[$];
  logic [DATA_W-1:0] hs_im[$];
  logic              hs_last[$];
  int                hs_cyc[$];
  logic              prev_stall = 1'b0;
  logic [33:0]       prev_vec   = '0;

  task automatic check_eq(input string tag, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: records handshakes, done/err pulses, and stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall)
        check_eq("stall_hold", {6'b0, bus.tw_valid, bus.tw_last, bus.tw_re, bus.tw_im},
                 {6'b0, prev_vec});
      prev_stall = bus.tw_valid && !bus.tw_ready;
      prev_vec   = {bus.tw_valid, bus.tw_last, bus.tw_re, bus.tw_im};
      if (bus.tw_valid && bus.tw_ready) begin
        hs_re.push_back(bus.tw_re);
        hs_im.push_back(bus.tw_im);
        hs_last.push_back(bus.tw_last);
        hs_cyc.push_back(cyc);
      end
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.err)  begin err_cnt++;  err_cyc  = cyc; end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.tw_ready = 1'b1;
        1:       bus.tw_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.tw_ready = 1'b0;
      endcase
    end
  endtask

  task automatic launch(input logic [4:0] b, input logic [4:0] s, input logic [5:0] c,
                        output int t0);
    hs_re.delete(); hs_im.delete(); hs_last.delete(); hs_cyc.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
    bus.base_addr = b;
    bus.stride    = s;
    bus.count     = c;
    bus.start     = 1'b1;
    t0 = cyc;
    step(1);
    bus.start = 1'b0;
  endtask

  // Compare captured handshakes with the expected modular address walk.
  task automatic check_stream(input string tag, input int b, input int s, input int c);
    int a;
    a = b;
    check_eq({tag, "_n"}, 40'(hs_re.size()), 40'(c));
    for (int i = 0; i < c && i < hs_re.size(); i++) begin
      check_eq({tag, "_re"}, 40'(hs_re[i]), 40'(a));
      check_eq({tag, "_im"}, 40'(hs_im[i]), 40'(32'hFF00 | a));
      check_eq({tag, "_last"}, 40'(hs_last[i]), 40'(i == c - 1));
      a = a + s;
      if (a >= 28) a = a - 28;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  40'(bus.busy), 40'(0));
    check_eq({tag, "_done"},  40'(bus.done), 40'(0));
    check_eq({tag, "_err"},   40'(bus.err), 40'(0));
    check_eq({tag, "_addr"},  40'(bus.rom_addr), 40'(0));
    check_eq({tag, "_valid"}, 40'(bus.tw_valid), 40'(0));
    check_eq({tag, "_re"},    40'(bus.tw_re), 40'(0));
    check_eq({tag, "_im"},    40'(bus.tw_im), 40'(0));
    check_eq({tag, "_last"},  40'(bus.tw_last), 40'(0));
  endtask

  initial begin
    int t0;
    int r;
    bus.start = 1'b0; bus.base_addr = '0; bus.stride = '0; bus.count = '0;
    bus.tw_ready = 1'b1;
    #2;
    check_reset_outputs("rst");
    step(3);
    rst = 1'b0;
    step(2);

    // Basic job with timing of first data, last and done.
    launch(5'd5, 5'd1, 6'd4, t0);
    check_eq("j1_busy", 40'(bus.busy), 40'(1));
    check_eq("j1_addr", 40'(bus.rom_addr), 40'(5));
    step(15);
    check_stream("j1", 5, 1, 4);
    for (int i = 0; i < 4 && i < hs_cyc.size(); i++)
      check_eq("j1_cyc", 40'(hs_cyc[i]), 40'(t0 + 3 + i));
    check_eq("j1_done_cyc", 40'(done_cyc), 40'(t0 + 7));
    check_eq("j1_done_cnt", 40'(done_cnt), 40'(1));
    check_eq("j1_busy_end", 40'(bus.busy), 40'(0));

    // Wrapping stride.
    launch(5'd20, 5'd4, 6'd5, t0);
    step(15);
    check_stream("j2", 20, 4, 5);
    check_eq("j2_done_cnt", 40'(done_cnt), 40'(1));

    // Ready toggling 1,0,0,1.
    rdy_mode = 1;
    launch(5'd0, 5'd1, 6'd16, t0);
    step(60);
    rdy_mode = 0;
    step(1);
    check_stream("j3", 0, 1, 16);
    check_eq("j3_done_cnt", 40'(done_cnt), 40'(1));

    // Long stall fills the buffer, then streams back to back.
    rdy_mode = 2;
    launch(5'd10, 5'd3, 6'd8, t0);
    step(9);
    rdy_mode = 0;
    step(1);
    r = cyc;
    step(15);
    check_stream("j4", 10, 3, 8);
    for (int i = 0; i < 8 && i < hs_cyc.size(); i++)
      check_eq("j4_cyc", 40'(hs_cyc[i]), 40'(r + i));

    // Empty job: done only; start held into the done cycle is ignored.
    launch(5'd3, 5'd1, 6'd0, t0);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(6);
    check_eq("j5_done_cnt", 40'(done_cnt), 40'(1));
    check_eq("j5_done_cyc", 40'(done_cyc), 40'(t0 + 1));
    check_eq("j5_err", 40'(err_cnt), 40'(0));
    check_eq("j5_hs", 40'(hs_re.size()), 40'(0));

    // Out-of-range base: err only.
    launch(5'd28, 5'd1, 6'd3, t0);
    step(6);
    check_eq("j6_err_cnt", 40'(err_cnt), 40'(1));
    check_eq("j6_err_cyc", 40'(err_cyc), 40'(t0 + 1));
    check_eq("j6_done", 40'(done_cnt), 40'(0));
    check_eq("j6_hs", 40'(hs_re.size()), 40'(0));

    // Start while busy is ignored.
    launch(5'd0, 5'd2, 6'd6, t0);
    step(2);
    bus.base_addr = 5'd1; bus.count = 6'd3; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(20);
    check_stream("j7", 0, 2, 6);
    check_eq("j7_done_cnt", 40'(done_cnt), 40'(1));

    // Reset during the third handshake of a 10-factor job.
    launch(5'd0, 5'd1, 6'd10, t0);
    for (int i = 0; i < 40 && hs_re.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("j8_reached", 40'(hs_re.size() >= 3), 40'(1));
    rst = 1'b1;
    #1;
    check_reset_outputs("j8_rst");
    step(2);
    rst = 1'b0;
    step(2);
    check_eq("j8_done", 40'(done_cnt), 40'(0));
    check_eq("j8_err", 40'(err_cnt), 40'(0));
    launch(5'd2, 5'd1, 6'd2, t0);
    step(12);
    check_stream("j9", 2, 1, 2);
    check_eq("j9_done_cnt", 40'(done_cnt), 40'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
